// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e       : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/sum width in bits
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : serial_add_pkg

// File: rtl/half_adder_cell.sv
// Single-bit half adder. Two of these plus an OR gate form the full-add cell
// that serial_add_ctrl reuses once per bit.
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through
// one shared full-add cell, taking WIDTH cycles per operation.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input selecting A-B.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   a_in, b_in          : operands, sampled on the accept edge only
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : registered result, held until the next completion
//   busy                : high in RUN or DONE
//   sub                 : (SERIAL_ADD_SUB_EN only) 1 = compute A-B
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_SUB_EN
  ,
  input  logic             sub
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_a_q, sreg_a_d;
  logic [WIDTH-1:0] sreg_b_q, sreg_b_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] b_load;
  logic             carry_init;
  logic             hs0, hc0, hc1;
  logic             bit_s, bit_c;

  // Subtraction is A + ~B + 1: invert B once on load and seed the carry.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b_in : b_in;
  assign carry_init = sub;
`else
  assign b_load     = b_in;
  assign carry_init = 1'b0;
`endif

  half_adder_cell u_ha0 (
    .a (sreg_a_q[0]),
    .b (sreg_b_q[0]),
    .s (hs0),
    .c (hc0)
  );

  half_adder_cell u_ha1 (
    .a (hs0),
    .b (carry_q),
    .s (bit_s),
    .c (hc1)
  );

  assign bit_c = hc0 | hc1;

  always_comb begin
    state_d  = state_q;
    sreg_a_d = sreg_a_q;
    sreg_b_d = sreg_b_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          sreg_a_d = a_in;
          sreg_b_d = b_load;
          sum_sr_d = '0;
          carry_d  = carry_init;
          cnt_d    = '0;
        end
      end
      RUN: begin
        sreg_a_d = {1'b0, sreg_a_q[WIDTH-1:1]};
        sreg_b_d = {1'b0, sreg_b_q[WIDTH-1:1]};
        sum_sr_d = {bit_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = bit_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Final bit: publish the shift register including this cycle's bit.
          state_d = DONE;
          sum_d   = sum_sr_d;
          cout_d  = bit_c;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sreg_a_q <= '0;
      sreg_b_q <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sreg_a_q <= sreg_a_d;
      sreg_b_q <= sreg_b_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8: vector table, corner-case
// sequences (held result, reset mid-run, in_valid during RUN) and random ops
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         sub_drv;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_SUB_EN
    ,
    .sub       (sub_drv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole operands.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic s);
    int unsigned ai, bi, r;
    ai = a;
    bi = b;
    if (s) begin
      r = (ai - bi) & ((1 << W) - 1);
      return {(ai >= bi), r[W-1:0]};
    end
    r = ai + bi;
    return r[W:0];
  endfunction

  // One full transaction. While the result is held (hold>0), in_valid is
  // driven with a different operand pair to confirm it is ignored.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] es, input logic ec, input int unsigned hold);
    int    lat;
    string tag;
    tag = $sformatf("op %02h,%02h sub=%0b", a, b, s);
    lat = 0;
    @(negedge clk);
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " in_ready_wait"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    sub_drv   = s;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    sub_drv  = 1'($urandom);
    chk({tag, " busy_run"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, W);
    chk({tag, " sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, " in_ready_done"}, {31'd0, in_ready}, 32'd0);
    for (int unsigned h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a_in     = 8'h11;
      b_in     = 8'h22;
      @(negedge clk);
      chk({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, " hold_sum"}, {23'd0, cout, sum}, {23'd0, ec, es});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rs;
    int   seen;
    int   lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    sub_drv   = 1'b0;

    vecs.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h01, 8'h7F, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h55, 8'h55, 1'b1, 8'h00, 1'b1});
`endif

    repeat (3) @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset sum", {24'd0, sum}, 32'd0);
    chk("reset cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_sum, vecs[i].exp_cout, 0);

    // Result held for 5 cycles, competing in_valid ignored, then a fresh op.
    do_op(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 5);
    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);

    // Reset while cnt==3: no result may ever surface.
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 8'hAA;
    b_in     = 8'h55;
    sub_drv  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst sum", {24'd0, sum}, 32'd0);
    chk("midrst cout", {31'd0, cout}, 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("midrst stale_result", seen, 0);

    // in_valid pulsed during RUN with other operands must not disturb the op.
    in_valid = 1'b1;
    a_in     = 8'h12;
    b_in     = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    a_in     = 8'h77;
    b_in     = 8'h88;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("runpulse out_valid", {31'd0, out_valid}, 32'd1);
    chk("runpulse sum", {24'd0, sum}, 32'h46);
    chk("runpulse cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    chk("runpulse in_ready", {31'd0, in_ready}, 32'd1);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      r = ref_op(ra, rb, rs);
      do_op(ra, rb, rs, r[W-1:0], r[W], $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequences a single shared 1-bit adder cell to add two WIDTH-bit operands bit-serially, LSB first.
- The cell is built from two half-adder instances plus an OR gate.
- Accepts operand pairs on a valid/ready input handshake and returns sum and carry-out on a valid/ready output handshake.
- Sits between the tile's input pins (ui_in/uio_in) and the output register driving uo_out. It trades WIDTH cycles of latency for one adder cell's area.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..16)
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- in_valid  input  1  operand pair on a_in/b_in is valid
- in_ready  output  1  block can accept an operand pair (high only in IDLE)
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- out_valid  output  1  sum/cout are valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result A+B mod 2^WIDTH
- cout  output  1  registered carry-out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; shift regs, carry flop, counter, sum and cout all cleared to 0.
  - in_ready=1, out_valid=0, busy=0 from the following cycle.
  - Reset wins over every other event, including mid-RUN and in DONE; any in-flight result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid & in_ready:
  - Latch a_in into sreg_a and b_in into sreg_b.
  - carry=0 (1 in subtract mode), cnt=0.
  - Clear the sum shift reg.
- RUN, one bit per cycle:
  - s = sreg_a[0]^sreg_b[0]^carry; c = majority(sreg_a[0], sreg_b[0], carry), computed via two half_adder_cell instances plus OR.
  - sreg_a and sreg_b shift right. s shifts into sum_sr MSB. carry<=c; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: move to DONE, copy sum_sr (with final s) to sum, and copy c to cout.
- DONE -> IDLE on out_ready. sum and cout hold their values until the next accepted result completes; they are not cleared on handshake.
- Latency: operands accepted at edge T gives out_valid=1 in the cycle after edge T+WIDTH. Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- in_valid while not in IDLE: ignored, nothing latched. a_in/b_in only need to be stable in the accept cycle.
- out_ready while out_valid=0: ignored.
- out_valid held with out_ready=0: remain in DONE indefinitely; sum/cout stable; in_ready=0.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on accept.
  - When sub=1, the B path is inverted before the cell and the carry flop initialises to 1, giving A-B mod 2^WIDTH.
  - cout=1 means no borrow (A>=B unsigned).
- Undefined:
  - No sub port; carry always initialises to 0; addition only.
  - No extra logic synthesised.

Decomposition:
- Package serial_add_pkg holds:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - DEFAULT_WIDTH=8
- Sub-module half_adder_cell (inputs a, b; outputs s=a^b, c=a&b), instantiated twice inside serial_add_ctrl to form the shared full-add cell.
- Counter and shift registers stay in the top block.

Test Plan:
- WIDTH=8, accept a=0x5A, b=0x3C, out_ready=1 -> out_valid exactly 8 cycles after the accept edge; sum=0x96, cout=0; in_ready returns next cycle.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0x00, b=0x00 -> sum=0x00, cout=0 (carry flop correctly reinitialised).
- Back-to-back: hold out_ready=0 for 5 cycles after out_valid -> sum/cout stable, in_ready=0, new in_valid with a=0x11 ignored; after release, next accepted pair computes correctly.
- Assert rst at cnt=3 during a=0xAA+b=0x55 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0x00, cout=0; no stale result ever appears.
- in_valid pulsed during RUN with different operands -> result equals the originally latched pair (0x12+0x34=0x46, cout=0).
- With SERIAL_ADD_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x01, b=0x02 -> sum=0xFF, cout=0.
